// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: serialises one byte per frame on baud strobes.
// Optional break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_frame_engine #(
  parameter logic       IDLE_LEVEL = 1'b1,
  parameter logic [4:0] BREAK_BITS = 5'd13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BaudSig_i,
  input  logic [7:0] Data_i,
  input  logic       DataValid_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  input  logic       StopBits2_i,
`ifdef UART_TX_BREAK_EN
  input  logic       Break_i,
`endif
  output logic       Ready_o,
  output logic       Busy_o,
  output logic       TxDone_o,
  output logic       Tx_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
`ifdef UART_TX_BREAK_EN
    , S_WAIT_BRK
    , S_BREAK
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       par_en_q, par_en_d;
  logic       stop2_q, stop2_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef UART_TX_BREAK_EN
  logic [4:0] brk_cnt_q, brk_cnt_d;
`else
  logic       unused_break_bits;
  assign unused_break_bits = ^BREAK_BITS;
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d = brk_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (Break_i) begin
          stop2_d = 1'b0;
          state_d = S_WAIT_BRK;
        end else
`endif
        if (DataValid_i && ready_q) begin
          shift_d  = Data_i;
          par_en_d = ParityEn_i;
          par_d    = ParityOdd_i ? ~^Data_i : ^Data_i;
          stop2_d  = StopBits2_i;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (BaudSig_i) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (BaudSig_i) begin
          tx_d    = shift_q[0];
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (BaudSig_i) begin
          if (cnt_q != 3'd7) begin
            // next bit is taken from the pre-shift register
            tx_d    = shift_q[1];
            shift_d = {1'b0, shift_q[7:1]};
            cnt_d   = cnt_q + 3'd1;
          end else if (par_en_q) begin
            tx_d    = par_q;
            state_d = S_PARITY;
          end else begin
            tx_d    = IDLE_LEVEL;
            state_d = S_STOP1;
          end
        end
      end
      S_PARITY: begin
        if (BaudSig_i) begin
          tx_d    = IDLE_LEVEL;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (BaudSig_i) begin
          if (stop2_q) begin
            state_d = S_STOP2;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_STOP2: begin
        if (BaudSig_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_WAIT_BRK: begin
        if (BaudSig_i) begin
          tx_d      = 1'b0;
          brk_cnt_d = '0;
          state_d   = S_BREAK;
        end
      end
      S_BREAK: begin
        if (BaudSig_i) begin
          // the WAIT_BRK strobe already opened the first low interval
          if (brk_cnt_q == BREAK_BITS - 5'd1) begin
            tx_d    = IDLE_LEVEL;
            state_d = S_STOP1;
          end else begin
            brk_cnt_d = brk_cnt_q + 5'd1;
          end
        end
      end
`endif
      default: begin
        tx_d    = IDLE_LEVEL;
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= IDLE_LEVEL;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q <= brk_cnt_d;
`endif
    end
  end

  assign Ready_o  = ready_q;
  assign Busy_o   = busy_q;
  assign TxDone_o = done_q;
  assign Tx_o     = tx_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Directed bench for uart_tx_frame_engine: table of frames plus corner-case sequences.
module tb_uart_tx_frame_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       BaudSig_i;
  logic [7:0] Data_i;
  logic       DataValid_i;
  logic       ParityEn_i;
  logic       ParityOdd_i;
  logic       StopBits2_i;
`ifdef UART_TX_BREAK_EN
  logic       Break_i;
`endif
  logic       Ready_o;
  logic       Busy_o;
  logic       TxDone_o;
  logic       Tx_o;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_frame_engine #(
    .IDLE_LEVEL(1'b1),
    .BREAK_BITS(5'd13)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .BaudSig_i  (BaudSig_i),
    .Data_i     (Data_i),
    .DataValid_i(DataValid_i),
    .ParityEn_i (ParityEn_i),
    .ParityOdd_i(ParityOdd_i),
    .StopBits2_i(StopBits2_i),
`ifdef UART_TX_BREAK_EN
    .Break_i    (Break_i),
`endif
    .Ready_o    (Ready_o),
    .Busy_o     (Busy_o),
    .TxDone_o   (TxDone_o),
    .Tx_o       (Tx_o)
  );

  // seq holds the expected Tx level after each strobe, first bit in seq[11]
  typedef struct {
    logic [7:0]  data;
    logic        pen;
    logic        podd;
    logic        st2;
    logic [11:0] seq;
    int unsigned len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int unsigned n);
    BaudSig_i = 1'b0;
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic strobe();
    BaudSig_i = 1'b1;
    tick();
    BaudSig_i = 1'b0;
  endtask

  // Strobes a whole frame from WAIT, scrambling config inputs while in flight.
  task automatic check_frame_bits(input logic [11:0] seq, input int unsigned len);
    for (int unsigned k = 1; k <= len; k++) begin
      ParityEn_i  = 1'($urandom);
      ParityOdd_i = 1'($urandom);
      StopBits2_i = 1'($urandom);
      strobe();
      chk($sformatf("bit%0d tx/done", k), {14'd0, Tx_o, TxDone_o}, {14'd0, seq[12-k], 1'b0});
      gap(3);
      chk($sformatf("bit%0d hold", k), {15'd0, Tx_o}, {15'd0, seq[12-k]});
    end
    ParityEn_i  = 1'b0;
    ParityOdd_i = 1'b0;
    StopBits2_i = 1'b0;
    strobe();
    chk("done edge tx/done/ready/busy", {12'd0, Tx_o, TxDone_o, Ready_o, Busy_o}, 16'b1110);
    tick();
    chk("done pulse width", {15'd0, TxDone_o}, 16'd0);
  endtask

  task automatic run_frame(input vec_t v);
    chk("ready before accept", {15'd0, Ready_o}, 16'd1);
    Data_i      = v.data;
    ParityEn_i  = v.pen;
    ParityOdd_i = v.podd;
    StopBits2_i = v.st2;
    DataValid_i = 1'b1;
    tick();
    DataValid_i = 1'b0;
    Data_i      = ~v.data;
    chk("after accept tx/ready/busy", {13'd0, Tx_o, Ready_o, Busy_o}, 16'b101);
    gap(3);
    check_frame_bits(v.seq, v.len);
    gap(2);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'b0101_0010_1100, 10};
    vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 12'b0110_0000_0011, 12};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b1, 12'b0110_0000_0111, 12};
    vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 12'b0000_0000_1010, 11};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 12'b0111_1111_1010, 11};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 12'b0000_0000_0110, 11};

    rst_n = 1'b0;
    BaudSig_i = 1'b0;
    Data_i = 8'h00;
    DataValid_i = 1'b0;
    ParityEn_i = 1'b0;
    ParityOdd_i = 1'b0;
    StopBits2_i = 1'b0;
`ifdef UART_TX_BREAK_EN
    Break_i = 1'b0;
`endif
    tick();
    tick();
    chk("reset tx/ready/busy/done", {12'd0, Tx_o, Ready_o, Busy_o, TxDone_o}, 16'b1100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int unsigned i = 0; i < 6; i++) run_frame(vecs[i]);

    // strobe on the accept edge must not start the frame
    Data_i = 8'hA5;
    DataValid_i = 1'b1;
    BaudSig_i = 1'b1;
    tick();
    BaudSig_i = 1'b0;
    DataValid_i = 1'b0;
    chk("coincident strobe tx/ready", {14'd0, Tx_o, Ready_o}, 16'b10);
    gap(3);
    check_frame_bits(12'b0101_0010_1100, 10);
    gap(2);

    // back-to-back: valid held, 0x55 then 0xAA
    Data_i = 8'h55;
    ParityEn_i = 1'b0;
    ParityOdd_i = 1'b0;
    StopBits2_i = 1'b0;
    DataValid_i = 1'b1;
    tick();
    Data_i = 8'hAA;
    chk("b2b first accept ready", {15'd0, Ready_o}, 16'd0);
    gap(3);
    check_frame_bits(12'b0101_0101_0100, 10);
    chk("b2b second accept ready", {15'd0, Ready_o}, 16'd0);
    DataValid_i = 1'b0;
    gap(2);
    chk("b2b idle interval tx", {15'd0, Tx_o}, 16'd1);
    check_frame_bits(12'b0010_1010_1100, 10);
    gap(2);

    // reset during data bit 4
    Data_i = 8'hA5;
    DataValid_i = 1'b1;
    tick();
    DataValid_i = 1'b0;
    gap(2);
    for (int unsigned k = 1; k <= 6; k++) begin
      strobe();
      gap(2);
    end
    chk("pre-reset tx (bit4)", {15'd0, Tx_o}, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset tx/ready/busy/done", {12'd0, Tx_o, Ready_o, Busy_o, TxDone_o}, 16'b1100);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_frame('{8'h3C, 1'b0, 1'b0, 1'b0, 12'b0001_1110_0100, 10});

`ifdef UART_TX_BREAK_EN
    Break_i = 1'b1;
    DataValid_i = 1'b1;
    Data_i = 8'h5A;
    StopBits2_i = 1'b1;
    tick();
    Break_i = 1'b0;
    DataValid_i = 1'b0;
    chk("break entry tx/ready", {14'd0, Tx_o, Ready_o}, 16'b10);
    gap(2);
    for (int unsigned k = 1; k <= 14; k++) begin
      strobe();
      chk($sformatf("break strobe%0d tx/done", k), {14'd0, Tx_o, TxDone_o},
          {14'd0, (k <= 13) ? 1'b0 : 1'b1, 1'b0});
      gap(2);
    end
    strobe();
    chk("break done tx/done/ready", {13'd0, Tx_o, TxDone_o, Ready_o}, 16'b111);
    tick();
    chk("break done pulse width", {15'd0, TxDone_o}, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
